// File: rtl/ide_cycle_sequencer_if.sv
// Bus bundle between the Amiga-side decode/IDE buffers and the IDE cycle sequencer.
// The master side drives the 68k strobes, address, decode and drive IORDY;
// the slave side (the sequencer) drives the ATA strobes, ROM enable and dtack.
interface ide_cycle_sequencer_if;
  logic       AS_n;
  logic       UDS_n;
  logic       LDS_n;
  logic       RW;
  logic [4:0] ADDR;
  logic       ide_access;
  logic       IORDY;
  logic       IDE_CS0_n;
  logic       IDE_CS1_n;
  logic [2:0] IDE_DA;
  logic       IDE_IOR_n;
  logic       IDE_IOW_n;
  logic       ROM_OE_n;
  logic       dtack;
  logic       timeout_err;

  modport master (
    output AS_n, UDS_n, LDS_n, RW, ADDR, ide_access, IORDY,
    input  IDE_CS0_n, IDE_CS1_n, IDE_DA, IDE_IOR_n, IDE_IOW_n, ROM_OE_n, dtack, timeout_err
  );

  modport slave (
    input  AS_n, UDS_n, LDS_n, RW, ADDR, ide_access, IORDY,
    output IDE_CS0_n, IDE_CS1_n, IDE_DA, IDE_IOR_n, IDE_IOW_n, ROM_OE_n, dtack, timeout_err
  );
endinterface

// File: rtl/ide_cycle_sequencer.sv
// Turns 68000 bus cycles in the autoconfigured IDE window into timed ATA PIO
// strobes or boot-ROM reads, and returns a registered dtack to the CPU side.
// ADDR[4:0] carries CPU address bits [16:12]: [4]=IDE/ROM, [3]=CS1/CS0, [2:0]=DA.
module ide_cycle_sequencer #(
  parameter int SETUP_CYC     = 1,
  parameter int STROBE_CYC    = 3,
  parameter int RECOVER_CYC   = 1,
  parameter int ROM_CYC       = 2,
  parameter int IORDY_TIMEOUT = 64
) (
  input  logic                 CLK,
  input  logic                 RESET_n,
  ide_cycle_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_STROBE, S_ACK, S_RECOVER, S_ROM_WAIT, S_ROM_ACK
  } state_t;

  // Largest count any state needs: the strobe minimum plus the full IORDY wait.
  localparam int CNT_A   = (STROBE_CYC + IORDY_TIMEOUT > SETUP_CYC) ? STROBE_CYC + IORDY_TIMEOUT : SETUP_CYC;
  localparam int CNT_B   = (RECOVER_CYC + 1 > ROM_CYC) ? RECOVER_CYC + 1 : ROM_CYC;
  localparam int CNT_MAX = (CNT_A > CNT_B) ? CNT_A : CNT_B;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  logic             r_as_meta, r_as_s;
  logic             r_ds_meta, r_ds_s;
  logic             r_rdy_meta, r_rdy_s;
  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  int               w_cnt_p1;
  logic             r_rw, r_cs1;
  logic             w_rw_next, w_cs1_next, w_latch, w_timeout;
  logic             r_cs0_n, r_cs1_n, r_ior_n, r_iow_n, r_rom_oe_n, r_dtack, r_timeout_err;
  logic [2:0]       r_da;

  // Cycles spent in the current state including this one, as a signed count.
  assign w_cnt_p1 = int'(r_cnt) + 1;

  // Two-flop synchronizers for the asynchronous 68k strobes and drive IORDY.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (!RESET_n) begin
      r_as_meta  <= 1'b0;
      r_as_s     <= 1'b0;
      r_ds_meta  <= 1'b0;
      r_ds_s     <= 1'b0;
      r_rdy_meta <= 1'b0;
      r_rdy_s    <= 1'b0;
    end else begin
      r_as_meta  <= ~bus.AS_n;
      r_as_s     <= r_as_meta;
      r_ds_meta  <= ~(bus.UDS_n & bus.LDS_n);
      r_ds_s     <= r_ds_meta;
      r_rdy_meta <= bus.IORDY;
      r_rdy_s    <= r_rdy_meta;
    end
  end

  // Next-state decision, cycle-attribute latching and timeout detection.
  // NOTE: every signal gets a default first so no path through the case can infer a latch.
  always_comb begin
    w_next    = r_state;
    w_timeout = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        // A new cycle is only taken after the post-recovery idle gap has elapsed.
        if (r_as_s && r_ds_s && bus.ide_access && w_cnt_p1 >= RECOVER_CYC + 1) begin
          if (bus.ADDR[4])  w_next = S_SETUP;
          else if (bus.RW)  w_next = S_ROM_WAIT;
        end
      end
      S_SETUP: begin
        if (!r_as_s)                      w_next = S_RECOVER;
        else if (w_cnt_p1 >= SETUP_CYC)   w_next = S_STROBE;
      end
      S_STROBE: begin
        if (!r_as_s) begin
          w_next = S_RECOVER;
        end else if (w_cnt_p1 >= STROBE_CYC) begin
          if (r_rdy_s) begin
            w_next = S_ACK;
          end else if (w_cnt_p1 >= STROBE_CYC + IORDY_TIMEOUT) begin
            w_next    = S_ACK;
            w_timeout = 1'b1;
          end
        end
      end
      S_ACK:      if (!r_as_s) w_next = S_RECOVER;
      S_RECOVER:  if (w_cnt_p1 >= RECOVER_CYC) w_next = S_IDLE;
      S_ROM_WAIT: begin
        if (!r_as_s)                   w_next = S_IDLE;
        else if (w_cnt_p1 >= ROM_CYC)  w_next = S_ROM_ACK;
      end
      S_ROM_ACK:  if (!r_as_s) w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase

    w_latch    = (r_state == S_IDLE) && (w_next == S_SETUP);
    w_rw_next  = w_latch ? bus.RW      : r_rw;
    w_cs1_next = w_latch ? bus.ADDR[3] : r_cs1;
  end

  // State register with a saturating counter cleared on every state entry.
  always_ff @(posedge CLK) begin
    if (!RESET_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state)  r_cnt <= '0;
      else if (r_cnt != '1)   r_cnt <= r_cnt + 1'b1;
    end
  end

  // Registered outputs decoded from the state being entered, so they switch on the transition edge.
  always_ff @(posedge CLK) begin
    if (!RESET_n) begin
      r_rw          <= 1'b0;
      r_cs1         <= 1'b0;
      r_da          <= '0;
      r_cs0_n       <= 1'b1;
      r_cs1_n       <= 1'b1;
      r_ior_n       <= 1'b1;
      r_iow_n       <= 1'b1;
      r_rom_oe_n    <= 1'b1;
      r_dtack       <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_rw  <= w_rw_next;
      r_cs1 <= w_cs1_next;
      if (w_latch) r_da <= bus.ADDR[2:0];
      // Chip select spans SETUP through RECOVER; only one of the two is ever low.
      r_cs0_n <= ~((w_next inside {S_SETUP, S_STROBE, S_ACK, S_RECOVER}) && !w_cs1_next);
      r_cs1_n <= ~((w_next inside {S_SETUP, S_STROBE, S_ACK, S_RECOVER}) &&  w_cs1_next);
      // Read strobe stays low through ACK so the CPU latches stable data; write strobe ends at ACK.
      r_ior_n       <= ~((w_next inside {S_STROBE, S_ACK}) && w_rw_next);
      r_iow_n       <= ~((w_next == S_STROBE) && !w_rw_next);
      r_rom_oe_n    <= ~(w_next inside {S_ROM_WAIT, S_ROM_ACK});
      r_dtack       <= w_next inside {S_ACK, S_ROM_ACK};
      r_timeout_err <= w_timeout;
    end
  end

  assign bus.IDE_CS0_n   = r_cs0_n;
  assign bus.IDE_CS1_n   = r_cs1_n;
  assign bus.IDE_DA      = r_da;
  assign bus.IDE_IOR_n   = r_ior_n;
  assign bus.IDE_IOW_n   = r_iow_n;
  assign bus.ROM_OE_n    = r_rom_oe_n;
  assign bus.dtack       = r_dtack;
  assign bus.timeout_err = r_timeout_err;

endmodule

// File: tb/tb_ide_cycle_sequencer.sv
// Directed bench for ide_cycle_sequencer. Each bus cycle pushes a modelled
// timeline of output edges to a scoreboard queue, records the DUT timeline,
// then pops and compares. Edge n = n-th rising CLK edge after AS_n falls.
module tb_ide_cycle_sequencer;

  localparam int T_DTACK_IDE     = 2 + 1 + 1 + 3;   // AS_n fall to dtack, IORDY ready
  localparam int T_STROBE_FALL   = 2 + 1 + 1;
  localparam int T_TIMEOUT_DTACK = T_STROBE_FALL + 3 + 64;
  localparam int RDY_NEVER       = 1000;

  typedef struct {
    int cs0_fall;  int cs1_fall;  int da;
    int ior_fall;  int ior_rise;  int iow_fall;  int iow_rise;
    int dtack_rise; int dtack_fall; int cs_rise;
    int oe_fall;   int oe_rise;   int timeouts;  int viol;
  } rec_t;

  logic CLK;
  logic RESET_n;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   n_fail = 0;
  rec_t sb_q[$];

  ide_cycle_sequencer_if bus ();

  ide_cycle_sequencer dut (
    .CLK     (CLK),
    .RESET_n (RESET_n),
    .bus     (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input int obs, input int exp_v);
    n_chk++;
    assert (obs === exp_v) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic rec_t blank_rec();
    rec_t r;
    r = '{default: -1};
    r.timeouts = 0;
    r.viol     = 0;
    return r;
  endfunction

  // Reference timeline of one bus cycle.
  function automatic rec_t model(input logic [4:0] addr, input logic rw, input logic access,
                                 input int rdy_edge, input int abort_edge);
    rec_t e;
    int   rdy_at, d, seen;
    e = blank_rec();
    if (access && addr[4]) begin
      if (addr[3]) e.cs1_fall = 3; else e.cs0_fall = 3;
      e.da = int'(addr[2:0]);
      if (abort_edge > 0) begin
        seen = abort_edge + 3;               // synchronized AS rise reaches the FSM
        e.cs_rise = seen + 1;
        if (seen > T_STROBE_FALL) begin
          if (rw) begin e.ior_fall = T_STROBE_FALL; e.ior_rise = seen; end
          else    begin e.iow_fall = T_STROBE_FALL; e.iow_rise = seen; end
        end
      end else begin
        rdy_at = (rdy_edge == 0) ? 0 : rdy_edge + 3;
        d = (rdy_at > T_DTACK_IDE) ? rdy_at : T_DTACK_IDE;
        if (d > T_TIMEOUT_DTACK) begin
          d = T_TIMEOUT_DTACK;
          e.timeouts = 1;
        end
        if (rw) begin e.ior_fall = T_STROBE_FALL; e.ior_rise = d + 3; end
        else    begin e.iow_fall = T_STROBE_FALL; e.iow_rise = d;     end
        e.dtack_rise = d;
        e.dtack_fall = d + 3;
        e.cs_rise    = d + 4;
      end
    end else if (access && !addr[4] && rw) begin
      e.oe_fall    = 3;
      e.dtack_rise = 5;
      e.dtack_fall = 8;
      e.oe_rise    = 8;
    end
    return e;
  endfunction

  task automatic compare_rec(input string name, input rec_t o, input rec_t e);
    check({name, ".cs0_fall"},   o.cs0_fall,   e.cs0_fall);
    check({name, ".cs1_fall"},   o.cs1_fall,   e.cs1_fall);
    check({name, ".da"},         o.da,         e.da);
    check({name, ".ior_fall"},   o.ior_fall,   e.ior_fall);
    check({name, ".ior_rise"},   o.ior_rise,   e.ior_rise);
    check({name, ".iow_fall"},   o.iow_fall,   e.iow_fall);
    check({name, ".iow_rise"},   o.iow_rise,   e.iow_rise);
    check({name, ".dtack_rise"}, o.dtack_rise, e.dtack_rise);
    check({name, ".dtack_fall"}, o.dtack_fall, e.dtack_fall);
    check({name, ".cs_rise"},    o.cs_rise,    e.cs_rise);
    check({name, ".oe_fall"},    o.oe_fall,    e.oe_fall);
    check({name, ".oe_rise"},    o.oe_rise,    e.oe_rise);
    check({name, ".timeouts"},   o.timeouts,   e.timeouts);
    check({name, ".viol"},       o.viol,       e.viol);
  endtask

  // One bus cycle: AS_n released on dtack, at abort_edge, or at a hard budget.
  // IORDY is 1 from the start when rdy_edge==0, else it rises after edge rdy_edge.
  task automatic run_cycle(input string name, input logic [4:0] addr, input logic rw,
                           input logic access, input int rdy_edge, input int abort_edge);
    rec_t o, e;
    int   rel;
    sb_q.push_back(model(addr, rw, access, rdy_edge, abort_edge));
    o   = blank_rec();
    rel = -1;
    @(negedge CLK);
    bus.ADDR       = addr;
    bus.RW         = rw;
    bus.ide_access = access;
    bus.IORDY      = (rdy_edge == 0);
    bus.AS_n       = 1'b0;
    bus.UDS_n      = 1'b0;
    bus.LDS_n      = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge CLK);
      if (o.cs0_fall < 0 && bus.IDE_CS0_n === 1'b0) begin o.cs0_fall = n; o.da = int'(bus.IDE_DA); end
      if (o.cs1_fall < 0 && bus.IDE_CS1_n === 1'b0) begin o.cs1_fall = n; o.da = int'(bus.IDE_DA); end
      if ((o.cs0_fall >= 0 || o.cs1_fall >= 0) && o.cs_rise < 0 &&
          bus.IDE_CS0_n === 1'b1 && bus.IDE_CS1_n === 1'b1) o.cs_rise = n;
      if (o.ior_fall < 0 && bus.IDE_IOR_n === 1'b0) o.ior_fall = n;
      if (o.ior_fall >= 0 && o.ior_rise < 0 && bus.IDE_IOR_n === 1'b1) o.ior_rise = n;
      if (o.iow_fall < 0 && bus.IDE_IOW_n === 1'b0) o.iow_fall = n;
      if (o.iow_fall >= 0 && o.iow_rise < 0 && bus.IDE_IOW_n === 1'b1) o.iow_rise = n;
      if (o.dtack_rise < 0 && bus.dtack === 1'b1) o.dtack_rise = n;
      if (o.dtack_rise >= 0 && o.dtack_fall < 0 && bus.dtack === 1'b0) o.dtack_fall = n;
      if (o.oe_fall < 0 && bus.ROM_OE_n === 1'b0) o.oe_fall = n;
      if (o.oe_fall >= 0 && o.oe_rise < 0 && bus.ROM_OE_n === 1'b1) o.oe_rise = n;
      if (bus.timeout_err === 1'b1) o.timeouts++;
      if ((bus.IDE_CS0_n === 1'b0 && bus.IDE_CS1_n === 1'b0) ||
          (bus.IDE_IOR_n === 1'b0 && bus.IDE_IOW_n === 1'b0)) o.viol++;
      if (rel < 0 && (bus.dtack === 1'b1 || n == abort_edge || n == 90)) begin
        bus.AS_n  = 1'b1;
        bus.UDS_n = 1'b1;
        bus.LDS_n = 1'b1;
        rel = n;
      end
      if (n == rdy_edge) bus.IORDY = 1'b1;
      if (rel >= 0 && n >= rel + 5) break;
    end
    bus.IORDY = 1'b1;
    e = sb_q.pop_front();
    compare_rec(name, o, e);
  endtask

  initial begin
    int quiet;
    RESET_n        = 1'b0;
    bus.AS_n       = 1'b1;
    bus.UDS_n      = 1'b1;
    bus.LDS_n      = 1'b1;
    bus.RW         = 1'b1;
    bus.ADDR       = '0;
    bus.ide_access = 1'b0;
    bus.IORDY      = 1'b1;

    // Reset state.
    repeat (3) @(negedge CLK);
    check("reset_outputs",
          int'({bus.IDE_CS0_n, bus.IDE_CS1_n, bus.IDE_IOR_n, bus.IDE_IOW_n, bus.ROM_OE_n,
                bus.dtack, bus.timeout_err, bus.IDE_DA}), 'b11111_0_0_000);
    RESET_n = 1'b1;
    repeat (4) @(negedge CLK);
    check("idle_outputs",
          int'({bus.IDE_CS0_n, bus.IDE_CS1_n, bus.IDE_IOR_n, bus.IDE_IOW_n, bus.ROM_OE_n,
                bus.dtack, bus.timeout_err}), 'b11111_0_0);

    // Main cycles.
    run_cycle("ide_rd_cs0_da2",  5'b10010, 1'b1, 1'b1, 0,         0);
    run_cycle("ide_wr_cs1_da7",  5'b11111, 1'b0, 1'b1, 0,         0);
    run_cycle("ide_rd_wait10",   5'b10101, 1'b1, 1'b1, 14,        0);
    run_cycle("ide_wr_stuck",    5'b11011, 1'b0, 1'b1, RDY_NEVER, 0);
    run_cycle("rom_rd",          5'b00000, 1'b1, 1'b1, 0,         0);
    run_cycle("rom_wr_ignored",  5'b00101, 1'b0, 1'b1, 0,         12);
    run_cycle("abort_in_setup",  5'b10011, 1'b1, 1'b1, 0,         1);
    run_cycle("no_ide_access",   5'b10010, 1'b1, 1'b0, 0,         12);
    run_cycle("b2b_rd_first",    5'b10001, 1'b1, 1'b1, 0,         0);
    run_cycle("b2b_rd_second",   5'b11010, 1'b1, 1'b1, 0,         0);

    // Reset asserted while the read strobe is active.
    @(negedge CLK);
    bus.ADDR = 5'b10110; bus.RW = 1'b1; bus.ide_access = 1'b1; bus.IORDY = 1'b1;
    bus.AS_n = 1'b0; bus.UDS_n = 1'b0; bus.LDS_n = 1'b0;
    repeat (5) @(negedge CLK);
    check("pre_reset_ior_n", int'(bus.IDE_IOR_n), 0);
    RESET_n = 1'b0;
    @(negedge CLK);
    check("reset_mid_strobe",
          int'({bus.IDE_CS0_n, bus.IDE_CS1_n, bus.IDE_IOR_n, bus.IDE_IOW_n, bus.ROM_OE_n,
                bus.dtack, bus.timeout_err, bus.IDE_DA}), 'b11111_0_0_000);
    bus.AS_n = 1'b1; bus.UDS_n = 1'b1; bus.LDS_n = 1'b1;
    repeat (2) @(negedge CLK);
    RESET_n = 1'b1;
    quiet = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge CLK);
      if (bus.dtack !== 1'b0 || bus.IDE_IOR_n !== 1'b1 || bus.IDE_IOW_n !== 1'b1 ||
          bus.IDE_CS0_n !== 1'b1 || bus.IDE_CS1_n !== 1'b1) quiet++;
    end
    check("post_reset_quiet", quiet, 0);

    // Normal operation resumes after the reset.
    run_cycle("after_reset_wr", 5'b10110, 1'b0, 1'b1, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
